regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Arbitrates two requester ports (e.g. ALU-side master, config/UART master) onto the single-port 8x16 register file (RegFile).
- Each access request is serialized into a one-cycle RegFile strobe (WrEn or RdEn), and read data is returned to the requester that owns the read.
- Ties between requesters are resolved round-robin. Sits directly between the system controller masters and RegFile.

Parameters:
- DATA_WIDTH, 16, width of write/read data.
- ADDR_WIDTH, 3, RegFile address width (8 entries).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high. Clears the FSM, pointer and all registered outputs.
- req0  in  1  requester 0 access request; held until gnt0.
- we0  in  1  requester 0 op: 1 = write, 0 = read.
- addr0  in  ADDR_WIDTH  requester 0 address.
- wdata0  in  DATA_WIDTH  requester 0 write data.
- gnt0  out  1  one-cycle pulse: requester 0 command accepted.
- rvalid0  out  1  one-cycle pulse: rdata0 holds requester 0 read result.
- rdata0  out  DATA_WIDTH  requester 0 read data; holds its value until the next requester 0 read response.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as the port 0 set, for requester 1.
- rf_WrEn  out  1  RegFile write enable.
- rf_RdEn  out  1  RegFile read enable.
- rf_address  out  ADDR_WIDTH  RegFile address.
- rf_WrData  out  DATA_WIDTH  RegFile write data.
- rf_RdData  in  DATA_WIDTH  RegFile read data; registered, valid the cycle after the rf_RdEn cycle.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered. Reset value of every output is 0. The round-robin pointer last_gnt resets to 1, so requester 0 wins the first tie.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE, no req: stay in IDLE.
- IDLE, one req high: select that requester.
- IDLE, both req high: select the requester != last_gnt.
- IDLE, on select: latch we/addr/wdata and the owner ID, update last_gnt, go to ACCESS.
- ACCESS lasts exactly 1 cycle:
  - gnt_owner = 1.
  - rf_address and rf_WrData come from the latched command.
  - rf_WrEn = we, rf_RdEn = ~we.
  - Write: next state IDLE. Read: next state RDWAIT.
- RDWAIT lasts exactly 1 cycle: capture rf_RdData into rdata_owner, go to IDLE. rvalid_owner = 1 in the following cycle (the first IDLE cycle).
- rf_WrEn and rf_RdEn are never both high, and are 0 outside ACCESS.
- rf_address and rf_WrData hold their last values outside ACCESS.
- Latency, measured from the IDLE edge that samples req:
  - gnt at +1 cycle.
  - Write commit at the end of +1.
  - rvalid at +3.
- Throughput: write = 2 cycles per access; read = 3 cycles per access.
- req is sampled only in IDLE. The requester must hold req/we/addr/wdata stable until it sees gnt, then drop or change them at that edge.
- A request arriving while busy waits in place; it is not lost.
- A continuously held req0/req1 pair alternates grants 0,1,0,1…
- rdata_x of one requester is unaffected by the other requester's traffic.
- Reset mid-operation (any state): next cycle is IDLE, all outputs are 0, and the in-flight command is dropped. A dropped read produces no rvalid; a write already strobed is not undone. The arbiter never resets RegFile contents.
- No address range check is needed: ADDR_WIDTH covers all 8 entries.

Test Plan:
1. Reset: rst=1 for 2 cycles with req0=req1=1 → all outputs 0, busy=0, no gnt during reset; first grant after release goes to requester 0.
2. Single-port write then read: req0 write addr 5, data AE55 → gnt0 and rf_WrEn at +1 with rf_address=5, rf_WrData=AE55. Then req0 read addr 5 → rf_RdEn at +1, rvalid0 at +3, rdata0=AE55.
3. Simultaneous writes: req0 write addr 2 = AD59, req1 write addr 3 = 4589 in the same cycle → gnt0 first, gnt1 two cycles later. Subsequent reads return rdata0=AD59 and rdata1=4589.
4. Fairness: both requesters hold continuous reads of addr 4 (written 0025) → grant order 0,1,0,1. Each rvalid pulse carries 0025 and is routed only to its owner.
5. Reset in RDWAIT: req1 read issued, rst asserted in the RDWAIT cycle → no rvalid1, rdata1 = 0, FSM in IDLE next cycle, busy=0.
6. Unwritten location and data hold: after RegFile reset, req0 reads addr 0 → rdata0=0. Then req1 writes addr 6 = 5467 → rdata0 stays 0, and a subsequent req0 read of addr 6 returns 5467.

Source files
------------

// File: rtl/regfile_arbiter_if.sv
// Requester and register-file signal bundle for regfile_arbiter.
// The master side drives requests and returns RegFile read data; the slave side is the arbiter.
interface regfile_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    logic                  rf_WrEn;
    logic                  rf_RdEn;
    logic [ADDR_WIDTH-1:0] rf_address;
    logic [DATA_WIDTH-1:0] rf_WrData;
    logic [DATA_WIDTH-1:0] rf_RdData;
    logic                  busy;

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, rf_RdData,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        input  rf_WrEn, rf_RdEn, rf_address, rf_WrData, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, rf_RdData,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
        output rf_WrEn, rf_RdEn, rf_address, rf_WrData, busy
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter serializing two requester ports onto a single-port register file.
// Every output is registered; read data is returned only to the requester that issued the read.
module regfile_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input logic              clk,
    input logic              rst,
    regfile_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StRdWait} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  sel;
    logic                  sel_we;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel        = 1'b0;
        sel_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that did not win last time goes first.
                    sel        = (bus.req0 && bus.req1) ? ~last_gnt_q : bus.req1;
                    sel_we     = sel ? bus.we1 : bus.we0;
                    owner_d    = sel;
                    last_gnt_d = sel;
                    gnt_d      = sel ? 2'b10 : 2'b01;
                    wr_en_d    = sel_we;
                    rd_en_d    = ~sel_we;
                    addr_d     = sel ? bus.addr1 : bus.addr0;
                    wdata_d    = sel ? bus.wdata1 : bus.wdata0;
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                state_d = wr_en_q ? StIdle : StRdWait;
            end
            StRdWait: begin
                if (owner_q) begin
                    rdata1_d = bus.rf_RdData;
                    rvalid_d = 2'b10;
                end else begin
                    rdata0_d = bus.rf_RdData;
                    rvalid_d = 2'b01;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.gnt0       = gnt_q[0];
    assign bus.gnt1       = gnt_q[1];
    assign bus.rvalid0    = rvalid_q[0];
    assign bus.rvalid1    = rvalid_q[1];
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.rf_WrEn    = wr_en_q;
    assign bus.rf_RdEn    = rd_en_q;
    assign bus.rf_address = addr_q;
    assign bus.rf_WrData  = wdata_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: hand sequences, a vector table and a randomized run
// checked against a transaction-level schedule model with a RegFile model attached.
module tb_regfile_arbiter;

    localparam int RN = 400;
    localparam int RS = RN + 32;

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd0;
        logic [15:0] exp_rd1;
    } vec_t;

    logic clk;
    logic rst;
    logic rf_clear;
    logic [15:0] rf_mem [8];
    int n_checks;
    int n_fail;

    // Randomized-phase expectations, indexed by cycle.
    bit          e_gnt  [RS][2];
    bit          e_rv   [RS][2];
    logic [15:0] e_rvd  [RS];
    bit          e_wr   [RS];
    bit          e_rd   [RS];
    bit          e_busy [RS];
    logic [2:0]  e_addr [RS];
    logic [15:0] e_wd   [RS];

    regfile_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

    regfile_arbiter #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RegFile with registered read data.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
            bus.rf_RdData <= '0;
        end else begin
            if (bus.rf_WrEn) rf_mem[bus.rf_address] <= bus.rf_WrData;
            if (bus.rf_RdEn) bus.rf_RdData <= rf_mem[bus.rf_address];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1,
                                   bus.rf_WrEn, bus.rf_RdEn, bus.busy}), 32'd0);
        check({name, "_rf"}, 32'({bus.rf_address, bus.rf_WrData}), 32'd0);
        check({name, "_rdata0"}, 32'(bus.rdata0), 32'd0);
        check({name, "_rdata1"}, 32'(bus.rdata1), 32'd0);
    endtask

    task automatic set_req(input int p, input logic r, input logic w, input logic [2:0] a,
                           input logic [15:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    task automatic do_reset(input logic clr);
        rst      = 1'b1;
        rf_clear = clr;
        tick();
        rst      = 1'b0;
        rf_clear = 1'b0;
    endtask

    // One uncontended transaction, started from an IDLE cycle and ending on the next IDLE cycle.
    task automatic xact(input int p, input logic we, input logic [2:0] a, input logic [15:0] d);
        set_req(p, 1'b1, we, a, d);
        tick();
        check("xact_gnt", 32'({bus.gnt0, bus.gnt1}), (p == 1) ? 32'd1 : 32'd2);
        check("xact_strobe", 32'({bus.rf_WrEn, bus.rf_RdEn}), 32'({we, ~we}));
        check("xact_addr", 32'(bus.rf_address), 32'(a));
        if (we) check("xact_wdata", 32'(bus.rf_WrData), 32'(d));
        set_req(p, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        if (!we) begin
            check("xact_rdwait", 32'({bus.busy, bus.rvalid0, bus.rvalid1}), 32'b100);
            tick();
            check("xact_rvalid", 32'({bus.rvalid0, bus.rvalid1}), (p == 1) ? 32'd1 : 32'd2);
        end
        check("xact_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin : main
        vec_t        tbl [10];
        int          gq [$];
        int          exp_next;
        int          n_gnt;
        int          n_rv;
        int          owner;
        bit          pend [2];
        logic        we_p [2];
        logic [2:0]  addr_p [2];
        logic [15:0] d_p [2];
        logic [15:0] hold [2];
        logic [15:0] ref_mem [8];
        int          last;
        int          free_at;
        int          w;

        n_checks = 0;
        n_fail   = 0;

        tbl[0] = '{0, 1'b0, 3'd0, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{1, 1'b1, 3'd6, 16'h5467, 16'h0000, 16'h0000};
        tbl[2] = '{0, 1'b0, 3'd6, 16'h0000, 16'h5467, 16'h0000};
        tbl[3] = '{0, 1'b1, 3'd5, 16'hAE55, 16'h5467, 16'h0000};
        tbl[4] = '{0, 1'b0, 3'd5, 16'h0000, 16'hAE55, 16'h0000};
        tbl[5] = '{1, 1'b0, 3'd5, 16'h0000, 16'hAE55, 16'hAE55};
        tbl[6] = '{1, 1'b1, 3'd7, 16'hFFFF, 16'hAE55, 16'hAE55};
        tbl[7] = '{1, 1'b0, 3'd7, 16'h0000, 16'hAE55, 16'hFFFF};
        tbl[8] = '{0, 1'b1, 3'd0, 16'h0001, 16'hAE55, 16'hFFFF};
        tbl[9] = '{1, 1'b0, 3'd0, 16'h0000, 16'hAE55, 16'h0001};

        // Reset held with both requesters asking; first grant after release goes to port 0.
        rst      = 1'b1;
        rf_clear = 1'b1;
        set_req(0, 1'b1, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd1, 16'h0);
        tick();
        rf_clear = 1'b0;
        check_zero("reset_c1");
        tick();
        check_zero("reset_c2");
        rst = 1'b0;
        tick();
        check("reset_first_gnt", 32'({bus.gnt0, bus.gnt1}), 32'd2);
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        tick();

        // Vector table from a cleared RegFile.
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) begin
            xact(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            check($sformatf("tbl%0d_rdata0", i), 32'(bus.rdata0), 32'(tbl[i].exp_rd0));
            check($sformatf("tbl%0d_rdata1", i), 32'(bus.rdata1), 32'(tbl[i].exp_rd1));
        end

        // Simultaneous writes: port 0 first, port 1 two cycles later.
        do_reset(1'b0);
        set_req(0, 1'b1, 1'b1, 3'd2, 16'hAD59);
        set_req(1, 1'b1, 1'b1, 3'd3, 16'h4589);
        tick();
        check("sim_gnt_a", 32'({bus.gnt0, bus.gnt1, bus.rf_WrEn}), 32'b101);
        check("sim_rf_a", 32'({bus.rf_address, bus.rf_WrData}), 32'({3'd2, 16'hAD59}));
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        check("sim_gap", 32'({bus.gnt0, bus.gnt1, bus.busy}), 32'd0);
        tick();
        check("sim_gnt_b", 32'({bus.gnt0, bus.gnt1, bus.rf_WrEn}), 32'b011);
        check("sim_rf_b", 32'({bus.rf_address, bus.rf_WrData}), 32'({3'd3, 16'h4589}));
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        xact(0, 1'b0, 3'd2, 16'h0);
        check("sim_rdata0", 32'(bus.rdata0), 32'h0000AD59);
        xact(1, 1'b0, 3'd3, 16'h0);
        check("sim_rdata1", 32'(bus.rdata1), 32'h00004589);

        // Fairness: both ports hold reads of addr 4; grants must alternate starting at port 0.
        xact(1, 1'b1, 3'd4, 16'h0025);
        set_req(0, 1'b1, 1'b0, 3'd4, 16'h0);
        set_req(1, 1'b1, 1'b0, 3'd4, 16'h0);
        exp_next = 0;
        n_gnt    = 0;
        n_rv     = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.gnt0 || bus.gnt1) begin
                owner = bus.gnt1 ? 1 : 0;
                check("fair_gnt", 32'({bus.gnt0, bus.gnt1}), (exp_next == 1) ? 32'd1 : 32'd2);
                gq.push_back(owner);
                exp_next ^= 1;
                n_gnt++;
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                n_rv++;
                if (gq.size() == 0) begin
                    check("fair_rv_unexpected", 32'({bus.rvalid0, bus.rvalid1}), 32'd0);
                end else begin
                    owner = gq.pop_front();
                    check("fair_rv_owner", 32'({bus.rvalid0, bus.rvalid1}),
                          (owner == 1) ? 32'd1 : 32'd2);
                    check("fair_rdata", (owner == 1) ? 32'(bus.rdata1) : 32'(bus.rdata0),
                          32'h00000025);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, 3'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        check("fair_gnt_count", 32'(n_gnt), 32'd4);
        check("fair_rv_count", 32'(n_rv), 32'd4);
        tick();
        check("fair_idle", 32'(bus.busy), 32'd0);

        // Reset during RDWAIT drops the read.
        set_req(1, 1'b1, 1'b0, 3'd3, 16'h0);
        tick();
        check("rst_rd_gnt", 32'({bus.gnt0, bus.gnt1, bus.rf_RdEn}), 32'b011);
        set_req(1, 1'b0, 1'b0, 3'd0, 16'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_rdwait");
        tick();
        check("rst_after", 32'({bus.rvalid1, bus.busy}), 32'd0);
        check("rst_after_rdata1", 32'(bus.rdata1), 32'd0);

        // Randomized traffic against a transaction-level schedule model.
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) ref_mem[i] = '0;
        for (int c = 0; c < RS; c++) begin
            e_gnt[c][0] = 0; e_gnt[c][1] = 0; e_rv[c][0] = 0; e_rv[c][1] = 0;
            e_wr[c] = 0; e_rd[c] = 0; e_busy[c] = 0;
            e_addr[c] = '0; e_wd[c] = '0; e_rvd[c] = '0;
        end
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; we_p[p] = 0; addr_p[p] = '0; d_p[p] = '0; hold[p] = '0;
        end
        last    = 1;
        free_at = 0;
        for (int c = 0; c < RS - 4; c++) begin
            for (int p = 0; p < 2; p++) if (e_rv[c][p]) hold[p] = e_rvd[c];
            check("rnd_ctl", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy,
                                  bus.rf_WrEn, bus.rf_RdEn}),
                  32'({e_gnt[c][0], e_gnt[c][1], e_rv[c][0], e_rv[c][1], e_busy[c],
                       e_wr[c], e_rd[c]}));
            check("rnd_rdata0", 32'(bus.rdata0), 32'(hold[0]));
            check("rnd_rdata1", 32'(bus.rdata1), 32'(hold[1]));
            if (e_wr[c] || e_rd[c]) check("rnd_addr", 32'(bus.rf_address), 32'(e_addr[c]));
            if (e_wr[c]) check("rnd_wdata", 32'(bus.rf_WrData), 32'(e_wd[c]));

            for (int p = 0; p < 2; p++) begin
                if (e_gnt[c][p]) pend[p] = 0;
                if (!pend[p] && c < RN && $urandom_range(2) == 0) begin
                    pend[p]   = 1;
                    we_p[p]   = 1'($urandom_range(1));
                    addr_p[p] = 3'($urandom_range(7));
                    d_p[p]    = 16'($urandom);
                end
                set_req(p, pend[p], we_p[p], addr_p[p], d_p[p]);
            end

            if (c >= free_at && (pend[0] || pend[1])) begin
                w    = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                last = w;
                e_gnt[c + 1][w] = 1;
                e_busy[c + 1]   = 1;
                e_addr[c + 1]   = addr_p[w];
                if (we_p[w]) begin
                    e_wr[c + 1]       = 1;
                    e_wd[c + 1]       = d_p[w];
                    ref_mem[addr_p[w]] = d_p[w];
                    free_at           = c + 2;
                end else begin
                    e_rd[c + 1]     = 1;
                    e_busy[c + 2]   = 1;
                    e_rv[c + 3][w]  = 1;
                    e_rvd[c + 3]    = ref_mem[addr_p[w]];
                    free_at         = c + 3;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
